// File: rtl/shifter_sll_iter.sv
// Multi-cycle logical left shifter: resolves one log2 stage of the shift amount per clock,
// with valid/ready handshakes on both the request and result sides.
module shifter_sll_iter #(
    parameter int unsigned N = 32,
    parameter int unsigned S = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [S-1:0] s,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] y,
    output logic         busy
);

    localparam int unsigned KW = $clog2(S + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e        r_state, w_state_next;
    logic [N-1:0]  r_acc, w_acc_next;
    logic [N-1:0]  r_y, w_y_next;
    logic [S-1:0]  r_sh, w_sh_next;
    logic [KW-1:0] r_k, w_k_next;
    logic [S-1:0]  w_amt;
    logic [N-1:0]  w_stage;

    // Stage k shifts by 2**k when bit k of the captured amount is set.
    always_comb begin
        w_amt   = S'(1) << r_k;
        w_stage = r_sh[r_k] ? (r_acc << w_amt) : r_acc;
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_sh_next    = r_sh;
        w_k_next     = r_k;
        w_y_next     = r_y;
        case (r_state)
            StIdle: begin
                if (i_valid) begin
                    w_acc_next   = a;
                    w_sh_next    = s;
                    w_k_next     = '0;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_acc_next = w_stage;
                w_k_next   = r_k + KW'(1);
                if (r_k == KW'(S - 1)) begin
                    w_y_next     = w_stage;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (o_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_sh    <= '0;
            r_k     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_sh    <= w_sh_next;
            r_k     <= w_k_next;
            r_y     <= w_y_next;
        end
    end

    // y is a separate register so it stays stable while the next operand is being shifted.
    assign i_ready = (r_state == StIdle);
    assign o_valid = (r_state == StDone);
    assign busy    = (r_state != StIdle);
    assign y       = r_y;

endmodule

// File: tb/tb_shifter_sll_iter.sv
// Self-checking bench for shifter_sll_iter: directed vector table, backpressure, mid-op reset
// and a random back-to-back stream compared against a plain a<<s reference.
module tb_shifter_sll_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] a;
    logic [4:0]  s;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] y;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    shifter_sll_iter #(.N(32), .S(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .a       (a),
        .s       (s),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .y       (y),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] y;
    } vec_t;

    function automatic logic [31:0] model(input logic [31:0] va, input logic [4:0] vs);
        logic [63:0] prod;
        prod = {32'd0, va} * (64'd1 << vs);
        return prod[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Ticks until o_valid is seen; returns edge count, or -1 if the bound expires.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !i_ready; i++) tick();
        check({name, "_ready_bound"}, {31'd0, i_ready}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] va, input logic [4:0] vs,
                          input logic [31:0] vy);
        int lat;
        wait_ready(name);
        a = va; s = vs; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        a = ~va; s = ~vs;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check({name, "_latency"}, lat, 5);
        check({name, "_y"}, y, vy);
        tick();
        check({name, "_iready_after"}, {31'd0, i_ready}, 32'd1);
        check({name, "_ovalid_after"}, {31'd0, o_valid}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int prev_cyc;
        logic [31:0] held_y, ra;
        logic [4:0]  rs;

        vecs[0] = '{32'h00000001, 5'd31, 32'h80000000};
        vecs[1] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
        vecs[2] = '{32'hDEADBEEF, 5'd4,  32'hEADBEEF0};
        vecs[3] = '{32'hDEADBEEF, 5'd16, 32'hBEEF0000};
        vecs[4] = '{32'hFFFFFFFF, 5'd31, 32'h80000000};
        vecs[5] = '{32'h12345678, 5'd13, 32'h8ACF0000};

        rst = 1'b1; i_valid = 1'b0; a = '0; s = '0; o_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_iready", {31'd0, i_ready}, 32'd1);
        check("reset_ovalid", {31'd0, o_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_y", y, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].y);
        end

        // Backpressure: result must hold while a competing request is ignored.
        o_ready = 1'b0;
        a = 32'hDEADBEEF; s = 5'd8; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", lat, 5);
        check("bp_y", y, 32'hADBEEF00);
        held_y = y;
        a = 32'h1; s = 5'd1; i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), {31'd0, o_valid}, 32'd1);
            check($sformatf("bp_hold_y%0d", i), y, held_y);
            check($sformatf("bp_hold_iready%0d", i), {31'd0, i_ready}, 32'd0);
        end
        o_ready = 1'b1;
        tick();
        check("bp_idle_iready", {31'd0, i_ready}, 32'd1);
        check("bp_idle_ovalid", {31'd0, o_valid}, 32'd0);
        tick();
        i_valid = 1'b0;
        wait_valid(lat);
        check("bp_next_latency", lat, 5);
        check("bp_next_y", y, 32'h2);
        tick();

        // Reset on the third SHIFT cycle discards the operation.
        wait_ready("rst_mid");
        a = 32'hFFFFFFFF; s = 5'd5; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_iready", {31'd0, i_ready}, 32'd1);
        check("rst_mid_ovalid", {31'd0, o_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_y", y, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rst_mid_quiet%0d", i), {31'd0, o_valid}, 32'd0);
        end
        run_op("after_rst", 32'h3, 5'd2, 32'hC);

        // Back-to-back random stream with both handshakes held high.
        o_ready = 1'b1;
        prev_cyc = 0;
        i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            a = ra; s = rs;
            wait_ready($sformatf("rnd%0d", i));
            tick();
            a = $urandom; s = 5'($urandom);
            wait_valid(lat);
            check($sformatf("rnd%0d_latency", i), lat, 5);
            check($sformatf("rnd%0d_y", i), y, model(ra, rs));
            if (i > 0) check($sformatf("rnd%0d_spacing", i), cyc - prev_cyc, 7);
            prev_cyc = cyc;
        end
        i_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
